poly_mac_sequencer: RTL and testbench

Sequential driver for the 256-lane parallel MAC array used in the schoolbook polynomial multiplier. It computes the negacyclic product acc = a·s mod (x^256 + 1, 2^13), one public coefficient per cycle:
- holds the 256×4-bit secret and rotates it negacyclically each step;
- holds the 256×13-bit accumulator and presents both registers to the array;
- writes the array's result back into the accumulator;
- streams the 256 finished coefficients out with a valid/ready handshake.

---
 rtl/poly_mac_sequencer_if.sv | 28 ++
 rtl/poly_mac_sequencer.sv | 87 ++++++++
 tb/tb_poly_mac_sequencer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/poly_mac_sequencer_if.sv
// Handshake and MAC-array bus between the polynomial multiplier sequencer and its environment.
// master = environment/array side, slave = sequencer side.
interface poly_mac_sequencer_if;
   logic          start;
   logic [1023:0] secret_in;
   logic          a_valid;
   logic          a_ready;
   logic [12:0]   a_data;
   logic [3327:0] mac_acc;
   logic [1023:0] mac_secret;
   logic [12:0]   mac_a_coeff;
   logic [3327:0] mac_result;
   logic          out_valid;
   logic          out_ready;
   logic [12:0]   out_data;
   logic          busy;
   logic          done;

   modport master (
      output start, secret_in, a_valid, a_data, mac_result, out_ready,
      input  a_ready, mac_acc, mac_secret, mac_a_coeff, out_valid, out_data, busy, done
   );

   modport slave (
      input  start, secret_in, a_valid, a_data, mac_result, out_ready,
      output a_ready, mac_acc, mac_secret, mac_a_coeff, out_valid, out_data, busy, done
   );
endinterface

// File: rtl/poly_mac_sequencer.sv
// Drives a 256-lane MAC array to form acc = a*s mod (x^256+1, 2^13), one a coefficient per cycle.
// Latency: 1 + 256 + 256 + 1 cycles start-to-done with no stalls.
// Backpressure: a_valid stalls the MAC phase, out_ready stalls the drain; all state holds meanwhile.
module poly_mac_sequencer (
   input logic                 clk,
   input logic                 rst,
   poly_mac_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MAC, DRAIN} state_t;

   state_t        state, state_nxt;
   logic [7:0]    cnt, cnt_nxt;
   logic [3327:0] acc, acc_nxt;
   logic [1023:0] secret, secret_nxt, secret_rot;
   logic [3:0]    wrap_coeff;
   logic [11:0]   lane_base;
   logic          done_q, done_nxt;

   // x^256 = -1: the coefficient leaving the top re-enters lane 0 negated (mod 16).
   assign wrap_coeff = 4'd0 - secret[1023:1020];
   assign secret_rot = {secret[1019:0], wrap_coeff};
   assign lane_base  = {4'd0, cnt} * 12'd13;

   assign bus.mac_acc     = acc;
   assign bus.mac_secret  = secret;
   assign bus.mac_a_coeff = bus.a_data;
   assign bus.busy        = (state != IDLE);
   assign bus.done        = done_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state  <= IDLE;
         cnt    <= '0;
         acc    <= '0;
         secret <= '0;
         done_q <= 1'b0;
      end else begin
         state  <= state_nxt;
         cnt    <= cnt_nxt;
         acc    <= acc_nxt;
         secret <= secret_nxt;
         done_q <= done_nxt;
      end
   end

   always_comb begin
      state_nxt     = state;
      cnt_nxt       = cnt;
      acc_nxt       = acc;
      secret_nxt    = secret;
      done_nxt      = 1'b0;
      bus.a_ready   = 1'b0;
      bus.out_valid = 1'b0;
      bus.out_data  = '0;
      case (state)
         IDLE: begin
            if (bus.start) begin
               secret_nxt = bus.secret_in;
               acc_nxt    = '0;
               cnt_nxt    = '0;
               state_nxt  = MAC;
            end
         end
         MAC: begin
            bus.a_ready = 1'b1;
            if (bus.a_valid) begin
               acc_nxt    = bus.mac_result;
               secret_nxt = secret_rot;
               cnt_nxt    = cnt + 8'd1;
               if (cnt == 8'd255) state_nxt = DRAIN;
            end
         end
         DRAIN: begin
            bus.out_valid = 1'b1;
            bus.out_data  = acc[lane_base +: 13];
            if (bus.out_ready) begin
               cnt_nxt = cnt + 8'd1;
               if (cnt == 8'd255) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end
endmodule

// File: tb/tb_poly_mac_sequencer.sv
// Directed bench for poly_mac_sequencer with a behavioural 256-lane MAC array.
module tb_poly_mac_sequencer;
   logic clk;
   logic rst;
   int   vectors;
   int   miscompares;
   int   cyc;
   logic [12:0] res  [256];
   logic [12:0] expv [256];

   poly_mac_sequencer_if bus ();

   poly_mac_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Array model: lane j = acc[j] + a * sext(s[j]), truncated to 13 bits.
   always_comb begin
      bus.mac_result = '0;
      for (int j = 0; j < 256; j++)
         bus.mac_result[13*j +: 13] = bus.mac_acc[13*j +: 13] +
            bus.mac_a_coeff * {{9{bus.mac_secret[4*j+3]}}, bus.mac_secret[4*j +: 4]};
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expd);
      vectors++;
      assert (obs === expd) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expd);
      end
   endtask

   task automatic do_start(input string name, input logic [1023:0] sec, output int c0);
      check({name, "_idle_a_ready"}, {31'd0, bus.a_ready}, 32'd0);
      check({name, "_idle_busy"}, {31'd0, bus.busy}, 32'd0);
      bus.start     = 1'b1;
      bus.secret_in = sec;
      c0 = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      check({name, "_mac_a_ready"}, {31'd0, bus.a_ready}, 32'd1);
      check({name, "_mac_busy"}, {31'd0, bus.busy}, 32'd1);
   endtask

   task automatic feed(input string name, input int n, input int mode, input bit toggle,
                       input int bad_at, input logic [1023:0] sec2);
      int i     = 0;
      int guard = 0;
      bit vld;
      while (i < n && guard < 2000) begin
         vld = toggle ? (guard % 2 == 0) : 1'b1;
         bus.a_valid = vld;
         bus.a_data  = (mode == 0) ? 13'(i) : ((i == 1) ? 13'd1 : 13'd0);
         if (i == bad_at && vld) begin
            bus.start     = 1'b1;
            bus.secret_in = sec2;
         end
         if (i == 3 && vld) begin
            #1;
            check({name, "_mac_a_coeff"}, {19'd0, bus.mac_a_coeff}, (mode == 0) ? 32'd3 : 32'd0);
         end
         @(negedge clk);
         bus.start = 1'b0;
         if (vld) i++;
         guard++;
      end
      bus.a_valid = 1'b0;
      bus.a_data  = '0;
      check({name, "_a_count"}, 32'(i), 32'(n));
   endtask

   task automatic drain(input string name, input int stall_k, input int stall_len);
      int  k       = 0;
      int  guard   = 0;
      int  stalled = 0;
      bit  rdy;
      while (k < 256 && guard < 3000) begin
         rdy = !(k == stall_k && stalled < stall_len);
         bus.out_ready = rdy;
         if (!rdy) begin
            check({name, "_stall_data"}, {19'd0, bus.out_data}, {19'd0, expv[k]});
            if (stalled == 0)
               check({name, "_stall_valid"}, {31'd0, bus.out_valid}, 32'd1);
            stalled++;
         end else if (bus.out_valid) begin
            res[k] = bus.out_data;
            k++;
         end
         @(negedge clk);
         guard++;
      end
      bus.out_ready = 1'b0;
      check({name, "_out_count"}, 32'(k), 32'd256);
   endtask

   task automatic run_job(input string name, input logic [1023:0] sec, input int mode,
                          input bit toggle, input int stall_k, input int bad_at,
                          input logic [1023:0] sec2, input int lat);
      int c0;
      int nbad = 0;
      do_start(name, sec, c0);
      feed(name, 256, mode, toggle, bad_at, sec2);
      drain(name, stall_k, 10);
      check({name, "_done"}, {31'd0, bus.done}, 32'd1);
      check({name, "_done_busy"}, {31'd0, bus.busy}, 32'd0);
      check({name, "_latency"}, 32'(cyc - c0 + 1), 32'(lat));
      @(negedge clk);
      check({name, "_done_pulse"}, {31'd0, bus.done}, 32'd0);
      for (int k = 0; k < 256; k++) begin
         if (res[k] !== expv[k] || k == 0 || k == 37 || k == 255)
            check($sformatf("%s_out%0d", name, k), {19'd0, res[k]}, {19'd0, expv[k]});
         if (res[k] !== expv[k]) nbad++;
      end
      check({name, "_bad_lanes"}, 32'(nbad), 32'd0);
   endtask

   initial begin
      logic [1023:0] s_one;
      logic [1023:0] s_top1;
      logic [1023:0] s_top8;
      vectors       = 0;
      miscompares   = 0;
      s_one         = 1024'd1;
      s_top1        = 1024'd1 << 1020;
      s_top8        = 1024'd8 << 1020;
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.secret_in = '0;
      bus.a_valid   = 1'b0;
      bus.a_data    = '0;
      bus.out_ready = 1'b0;
      #1;
      check("rst_a_ready", {31'd0, bus.a_ready}, 32'd0);
      check("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
      check("rst_out_data", {19'd0, bus.out_data}, 32'd0);
      check("rst_busy", {31'd0, bus.busy}, 32'd0);
      check("rst_done", {31'd0, bus.done}, 32'd0);
      check("rst_mac_acc", {31'd0, |bus.mac_acc}, 32'd0);
      check("rst_mac_secret", {31'd0, |bus.mac_secret}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);

      for (int k = 0; k < 256; k++) expv[k] = 13'(k);
      run_job("ident", s_one, 0, 1'b0, -1, -1, '0, 514);

      for (int k = 0; k < 256; k++) expv[k] = 13'd0;
      expv[0] = 13'h1FFF;
      run_job("wrap", s_top1, 1, 1'b0, -1, -1, '0, 514);

      expv[0] = 13'd8184;
      run_job("edge", s_top8, 1, 1'b0, -1, -1, '0, 514);

      for (int k = 0; k < 256; k++) expv[k] = 13'(k);
      run_job("bp", s_one, 0, 1'b1, 37, -1, '0, 779);

      run_job("busy_start", s_one, 0, 1'b0, -1, 50, 1024'd3, 514);

      begin
         int c0;
         do_start("rst_mid", 1024'd5, c0);
         feed("rst_mid", 100, 0, 1'b0, -1, '0);
         rst = 1'b1;
         #1;
         check("rst_mid_a_ready", {31'd0, bus.a_ready}, 32'd0);
         check("rst_mid_out_valid", {31'd0, bus.out_valid}, 32'd0);
         check("rst_mid_out_data", {19'd0, bus.out_data}, 32'd0);
         check("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
         check("rst_mid_done", {31'd0, bus.done}, 32'd0);
         check("rst_mid_mac_acc", {31'd0, |bus.mac_acc}, 32'd0);
         check("rst_mid_mac_secret", {31'd0, |bus.mac_secret}, 32'd0);
         @(negedge clk);
         rst = 1'b0;
         @(negedge clk);
      end
      run_job("post_rst", s_one, 0, 1'b0, -1, -1, '0, 514);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
